// File: rtl/filter_mux_scheduler.sv
// filter_mux_scheduler: round-robin time-shared 2-tap average / decimate-by-2 over NCH channels.
module filter_mux_scheduler #(
  parameter int NCH = 4,
  parameter int W = 16,
  localparam int CW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  input  logic             out_ready,
  output logic             busy
);
  logic [W-1:0] data_a [NCH];
  logic [W-1:0] prev_q [NCH];
  logic [W-1:0] prev_d [NCH];
  logic [NCH-1:0] phase_q, phase_d, elig;
  logic [CW-1:0] rr_q, rr_d, out_ch_q, out_ch_d, g, idx;
  logic [W-1:0] out_data_q, out_data_d, din;
  logic [W:0] sum;
  logic out_valid_q, out_valid_d, found, slot_free;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign data_a[i] = in_data[i*W +: W];
  end

  assign slot_free = !out_valid_q || out_ready;
  // Phase-0 samples never need the output slot, so a stall only blocks pair completions.
  assign elig = in_valid & (~phase_q | {NCH{slot_free}});

  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_q) + k) % NCH);
      if (elig[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end

  assign in_ready = {NCH{found && !rst}} & (NCH'(1) << g);
  assign din = data_a[g];
  assign sum = {prev_q[g][W-1], prev_q[g]} + {din[W-1], din};

  always_comb begin
    prev_d = prev_q;
    phase_d = phase_q;
    rr_d = rr_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d = out_data_q;
    out_ch_d = out_ch_q;
    if (found) begin
      prev_d[g] = din;
      phase_d[g] = !phase_q[g];
      rr_d = (int'(g) == NCH - 1) ? '0 : g + 1'b1;
      out_valid_d = phase_q[g] || out_valid_d;
      out_data_d = phase_q[g] ? sum[W:1] : out_data_q;
      out_ch_d = phase_q[g] ? g : out_ch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) prev_q[i] <= '0;
      phase_q <= '0;
      rr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
    end else begin
      prev_q <= prev_d;
      phase_q <= phase_d;
      rr_q <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign busy = out_valid_q || |in_valid;
endmodule

// File: tb/tb_filter_mux_scheduler.sv
// tb_filter_mux_scheduler: directed and random traffic against a per-channel pairing model and output scoreboard.
module tb_filter_mux_scheduler;
  localparam int NCH = 4;
  localparam int W = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0] in_ready;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic out_ready = 1'b1;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW+W-1:0] sb[$];
  logic [W-1:0] m_prev [NCH];
  logic [NCH-1:0] m_phase, el, fire, exp_rdy;
  logic [CW-1:0] m_rr, exp_ch, hc;
  logic [W-1:0] hd;
  logic [CW+W-1:0] e;
  logic exp_next = 1'b0;
  logic hold = 1'b0;
  logic slot;
  int waits [NCH];
  int eg;

  filter_mux_scheduler #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] avg(logic [W-1:0] a, logic [W-1:0] b);
    int s = int'($signed(a)) + int'($signed(b));
    return W'(s >>> 1);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", in_ready, 0);
      m_phase = '0;
      m_rr = '0;
      sb.delete();
      exp_next = 1'b0;
      hold = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_prev[i] = '0;
        waits[i] = 0;
      end
    end else begin
      if (exp_next) begin
        chk("lat_valid", out_valid, 1);
        chk("lat_ch", out_ch, exp_ch);
      end
      if (hold) begin
        chk("stable_data", out_data, hd);
        chk("stable_ch", out_ch, hc);
      end
      slot = !out_valid || out_ready;
      el = in_valid & (~m_phase | {NCH{slot}});
      eg = -1;
      for (int k = 0; k < NCH; k++)
        if (eg < 0 && el[CW'((int'(m_rr) + k) % NCH)]) eg = (int'(m_rr) + k) % NCH;
      exp_rdy = (eg < 0) ? '0 : NCH'(1) << eg;
      chk("grant", in_ready, exp_rdy);
      for (int i = 0; i < NCH; i++) begin
        if (el[i]) begin
          waits[i] = in_ready[i] ? 0 : waits[i] + 1;
          chk("fair", 32'(waits[i] < NCH), 1);
        end else waits[i] = 0;
      end
      if (out_valid && out_ready) begin
        chk("sb_pop", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_ch", out_ch, e[W +: CW]);
          chk("out_data", out_data, e[W-1:0]);
        end
      end
      fire = in_valid & in_ready;
      exp_next = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (fire[i]) begin
          if (m_phase[i]) begin
            sb.push_back({CW'(i), avg(m_prev[i], in_data[i*W +: W])});
            exp_next = 1'b1;
            exp_ch = CW'(i);
          end
          m_prev[i] = in_data[i*W +: W];
          m_phase[i] = !m_phase[i];
          m_rr = CW'((i + 1) % NCH);
        end
      end
      hold = out_valid && !out_ready;
      hd = out_data;
      hc = out_ch;
    end
  end

  task automatic send(int ch, logic [W-1:0] d);
    logic ok = 1'b0;
    in_data[ch*W +: W] = d;
    in_valid[ch] = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready[ch];
    end
    @(posedge clk);
    #1;
    in_valid[ch] = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_dir", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = '0;
    send(0, 16'd100);
    chk("p0_no_out", out_valid, 0);
    send(0, 16'd300);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 16'd200);
    chk("t1_ch", out_ch, 0);

    send(1, 16'h7fff);
    send(1, 16'h7fff);
    chk("max_pair", out_data, 16'h7fff);
    chk("max_ch", out_ch, 1);
    send(1, 16'h8000);
    send(1, 16'h8000);
    chk("min_pair", out_data, 16'h8000);
    send(1, 16'hfffd);
    send(1, 16'h0000);
    chk("neg_floor", out_data, 16'hfffe);
    send(1, 16'h0001);
    send(1, 16'h0000);
    chk("pos_floor", out_data, 16'h0000);

    in_valid = '1;
    repeat (24) begin
      in_data = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    do_reset();
    out_ready = 1'b0;
    send(3, 16'd7);
    send(3, 16'd9);
    chk("stall_pend", out_valid, 1);
    chk("stall_val", out_data, 16'd8);
    send(0, 16'd50);
    send(1, 16'd1);
    in_data[0*W +: W] = 16'd60;
    in_data[1*W +: W] = 16'd3;
    in_valid[1:0] = 2'b11;
    repeat (5) begin
      @(negedge clk);
      chk("stall_block", in_ready, 0);
      chk("stall_data", out_data, 16'd8);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk("b2b_valid0", out_valid, 1);
    chk("b2b_ch0", out_ch, 0);
    chk("b2b_data0", out_data, 16'd55);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_ch1", out_ch, 1);
    chk("b2b_data1", out_data, 16'd2);

    send(2, 16'd999);
    do_reset();
    send(2, 16'd10);
    send(2, 16'd20);
    chk("rst_pair_data", out_data, 16'd15);
    chk("rst_pair_ch", out_ch, 2);

    repeat (400) begin
      in_valid = NCH'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
    chk("idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
